// File: rtl/shift_seq_pkg.sv
// Shared encodings for the shift sequencer: FSM states, shifter modes and directions.
package shift_seq_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [1:0] MODE_LOGIC = 2'b00;
    localparam logic [1:0] MODE_ROT   = 2'b01;
    localparam logic [1:0] MODE_ARITH = 2'b10;
    localparam logic [1:0] MODE_RSVD  = 2'b11;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // The reserved encoding is never passed to the shifter; it degrades to a logical shift.
    function automatic logic [1:0] map_mode(input logic [1:0] mode);
        return (mode == MODE_RSVD) ? MODE_LOGIC : mode;
    endfunction

endpackage

// File: rtl/shift_sequencer_step_tick_gen.sv
// Step-pacing prescaler: counts 0..DIV_MAX while enabled and raises a registered
// one-cycle tick for the cycle in which the count sits at DIV_MAX.
module step_tick_gen #(
    parameter int          DIV_W   = 24,
    parameter int unsigned DIV_MAX = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] cnt_nxt;

    always_comb begin
        cnt_nxt = (cnt == DIV_W'(DIV_MAX)) ? '0 : cnt + DIV_W'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (en) begin
            cnt  <= cnt_nxt;
            tick <= (cnt_nxt == DIV_W'(DIV_MAX));
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// Command sequencer for the 8-bit shifter: load, paced shift strobes, result capture.
// Optional SHIFT_SEQ_PAUSE_EN adds a pause input that freezes stepping while in RUN.
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int          BIT_WIDTH = 8,
    parameter int          STEP_W    = 4,
    parameter int          DIV_W     = 24,
    parameter int unsigned DIV_MAX   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [BIT_WIDTH-1:0] cmd_data,
    input  logic                 cmd_dir,
    input  logic [1:0]           cmd_mode,
    input  logic [STEP_W-1:0]    cmd_steps,
    input  logic [BIT_WIDTH-1:0] q_in,
`ifdef SHIFT_SEQ_PAUSE_EN
    input  logic                 pause,
`endif
    output logic                 sh_load,
    output logic [BIT_WIDTH-1:0] sh_data,
    output logic                 sh_en,
    output logic                 sh_dir,
    output logic [1:0]           sh_mode,
    output logic                 busy,
    output logic                 done,
    output logic [BIT_WIDTH-1:0] result
);

    logic [1:0]        state;
    logic [STEP_W-1:0] remaining;
    logic              tick;
    logic              tick_en;

`ifdef SHIFT_SEQ_PAUSE_EN
    assign tick_en = (state == ST_RUN) && !pause;
`else
    assign tick_en = (state == ST_RUN);
`endif

    // The prescaler is held clear outside RUN, so its tick can only appear during RUN.
    step_tick_gen #(
        .DIV_W   (DIV_W),
        .DIV_MAX (DIV_MAX)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (state != ST_RUN),
        .en   (tick_en),
        .tick (tick)
    );

    assign sh_en = tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            remaining <= '0;
            sh_load   <= 1'b0;
            sh_data   <= '0;
            sh_dir    <= 1'b0;
            sh_mode   <= MODE_LOGIC;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
        end else begin
            sh_load <= 1'b0;
            done    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_LOAD;
                        remaining <= cmd_steps;
                        sh_load   <= 1'b1;
                        sh_data   <= cmd_data;
                        sh_dir    <= cmd_dir;
                        sh_mode   <= map_mode(cmd_mode);
                        busy      <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    state <= (remaining == '0) ? ST_DONE : ST_RUN;
                end
                ST_RUN: begin
                    // The shifter consumes sh_en on this same edge, so the last step moves straight to DONE.
                    if (tick) begin
                        remaining <= remaining - STEP_W'(1);
                        if (remaining == STEP_W'(1)) begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    done   <= 1'b1;
                    result <= q_in;
                    busy   <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
